des_key_schedule: RTL and testbench

//  Sequential DES subkey generator; upstream of the DES round datapath, which consumes one 48-bit subkey per round.

---
 rtl/des_key_schedule.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_des_key_schedule.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES subkey generator.
// Loads a 64-bit key through PC-1, rotates the C/D halves once per round and
// presents PC-2(C,D) as a 48-bit subkey over a valid/ready handshake, in
// K1..K16 order (encrypt) or K16..K1 order (decrypt).
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (odd-parity check of every
// key byte on start; failing keys are rejected and flag key_err).
// KEY_W and SUBKEY_W are fixed at 64 and 48; OUT_REG=1 adds one output stage.

module des_key_schedule #(
    parameter int KEY_W    = 64,
    parameter int SUBKEY_W = 48,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_W-1:0]    key,
    input  logic                decrypt,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round,
    output logic                busy,
    output logic                done,
    output logic                key_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    localparam int CD_W  = 56;
    localparam int SK_W  = 48;
    localparam int KB_W  = 64;

    // PC-1: table bit n selects key[64-n]; first 28 entries form C, rest D
    localparam logic [6:0] PC1_TAB [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: table bit n selects cd[56-n], where cd = {C,D}
    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = 56'd0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KB_W - int'(PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = 48'd0;
        for (int i = 0; i < SK_W; i++) begin
            r[SK_W-1-i] = cd[CD_W - int'(PC2_TAB[i])];
        end
        return r;
    endfunction

    // Encrypt shift amount for key-schedule step idx (0-based)
    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        logic [1:0] r;
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd15: r = 2'd1;
            default:                 r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        if (n == 2'd2) begin
            r = {x[25:0], x[27:26]};
        end else begin
            r = {x[26:0], x[27]};
        end
        return r;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        if (n == 2'd2) begin
            r = {x[1:0], x[27:2]};
        end else begin
            r = {x[0], x[27:1]};
        end
        return r;
    endfunction

    // True when every byte of the key carries odd parity
    function automatic logic key_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction

    state_t        state_r, state_s;
    logic [27:0]   c_r, c_s, d_r, d_s;
    logic [3:0]    round_r, round_s;
    logic          dec_r, dec_s;
    logic          busy_r, busy_s;
    logic          done_r;
    logic [55:0]   pc1_s;
    logic [47:0]   core_subkey_s;
    logic          core_valid_s, core_ready_s, core_fire_s;
    logic          key_ok_s, start_req_s, start_acc_s;
    logic          out_fire_s, last_out_s;

    assign pc1_s         = pc1(key[63:0]);
    assign core_subkey_s = pc2({c_r, d_r});
    assign core_valid_s  = (state_r == ST_GEN);
    assign core_fire_s   = core_valid_s & core_ready_s;
    assign start_req_s   = start & ~busy_r & (state_r == ST_IDLE);
    assign start_acc_s   = start_req_s & key_ok_s;
    assign out_fire_s    = subkey_valid & subkey_ready;
    assign last_out_s    = out_fire_s & (round == 4'd15);
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic key_err_r;

    assign key_ok_s = key_parity_ok(key[63:0]);
    assign key_err  = key_err_r;

    // Parity error flag: set by a rejected start, cleared by an accepted one
    always_ff @(posedge clk) begin
        if (rst) begin
            key_err_r <= 1'b0;
        end else if (start_acc_s) begin
            key_err_r <= 1'b0;
        end else if (start_req_s) begin
            key_err_r <= 1'b1;
        end else begin
            key_err_r <= key_err_r;
        end
    end
`else
    assign key_ok_s = 1'b1;
    assign key_err  = 1'b0;
`endif

    // Next-state logic: load on start, rotate C/D on each accepted subkey
    always_comb begin
        state_s = state_r;
        c_s     = c_r;
        d_s     = d_r;
        round_s = round_r;
        dec_s   = dec_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_s = ST_GEN;
                    round_s = 4'd0;
                    dec_s   = decrypt;
                    if (decrypt) begin
                        // K16 has a cumulative shift of 28, i.e. unrotated
                        c_s = pc1_s[55:28];
                        d_s = pc1_s[27:0];
                    end else begin
                        c_s = rotl28(pc1_s[55:28], 2'd1);
                        d_s = rotl28(pc1_s[27:0], 2'd1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (core_fire_s) begin
                    if (round_r == 4'd15) begin
                        state_s = ST_IDLE;
                    end else begin
                        round_s = round_r + 4'd1;
                        if (dec_r) begin
                            // Undo the encrypt shift of the subkey just emitted
                            c_s = rotr28(c_r, shift_amt(4'd15 - round_r));
                            d_s = rotr28(d_r, shift_amt(4'd15 - round_r));
                        end else begin
                            c_s = rotl28(c_r, shift_amt(round_r + 4'd1));
                            d_s = rotl28(d_r, shift_amt(round_r + 4'd1));
                        end
                    end
                end else begin
                    state_s = ST_GEN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Busy spans from accepted start to the last handshake seen at the outputs
    always_comb begin
        busy_s = busy_r;
        if (start_acc_s) begin
            busy_s = 1'b1;
        end else if (last_out_s) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy_r;
        end
    end

    // Core state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            c_r     <= 28'd0;
            d_r     <= 28'd0;
            round_r <= 4'd0;
            dec_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            c_r     <= c_s;
            d_r     <= d_s;
            round_r <= round_s;
            dec_r   <= dec_s;
            busy_r  <= busy_s;
            done_r  <= last_out_s;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            assign subkey       = core_subkey_s;
            assign subkey_valid = core_valid_s;
            assign round        = round_r;
            assign core_ready_s = subkey_ready;
        end else begin : g_outreg
            logic [47:0] o_subkey_r;
            logic        o_valid_r;
            logic [3:0]  o_round_r;

            assign subkey       = o_subkey_r;
            assign subkey_valid = o_valid_r;
            assign round        = o_round_r;
            // Core advances whenever the output stage is empty or draining
            assign core_ready_s = ~o_valid_r | subkey_ready;

            // Output stage: one-entry pipeline register between core and consumer
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_subkey_r <= 48'd0;
                    o_valid_r  <= 1'b0;
                    o_round_r  <= 4'd0;
                end else if (core_fire_s) begin
                    o_subkey_r <= core_subkey_s;
                    o_valid_r  <= 1'b1;
                    o_round_r  <= round_r;
                end else if (o_valid_r && subkey_ready) begin
                    o_valid_r  <= 1'b0;
                end else begin
                    o_valid_r  <= o_valid_r;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed testbench for des_key_schedule (default OUT_REG=0 build).
// Uses the classic key 133457799BBCDFF1 whose subkeys K1..K16 are tabulated,
// plus keys whose non-parity bits are all 0 or all 1 (every subkey 0 / all 1).

module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;
    logic        key_err;

    int checks;
    int errors;

    typedef struct {
        logic [63:0]     key;
        logic            dec;
        logic [767:0]    exp;   // emission i at exp[i*48 +: 48]
    } vec_t;

    logic [47:0]  ks [16];
    vec_t         vecs [4];
    logic [767:0] enc_exp;
    logic [63:0]  main_key;

    des_key_schedule #(.KEY_W(64), .SUBKEY_W(48), .OUT_REG(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .busy         (busy),
        .done         (done),
        .key_err      (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Runs one schedule; caller is at a negedge. Ends at a negedge, idle.
    task automatic run_sched(input logic [63:0] k, input logic d, input logic [767:0] exp,
                             input bit rnd_ready, input bit glitch);
        int          hs;
        int          cyc;
        bit          stalled;
        logic [47:0] held_sk;
        logic [3:0]  held_rnd;
        key     = k;
        decrypt = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        hs      = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_sk = 48'd0;
        held_rnd = 4'd0;
        while (hs < 16 && cyc < 200) begin
            chk("valid_busy", {62'd0, subkey_valid, busy}, 64'd3);
            chk("no_early_done", {63'd0, done}, 64'd0);
            if (stalled) begin
                chk("stall_subkey", {16'd0, subkey}, {16'd0, held_sk});
                chk("stall_round", {60'd0, round}, {60'd0, held_rnd});
            end
            if (glitch) begin
                start   = (hs == 5) || (hs == 15);
                key     = ~k;
                decrypt = ~d;
            end
            subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_valid && subkey_ready) begin
                chk($sformatf("subkey_%0d", hs), {16'd0, subkey}, {16'd0, exp[hs*48 +: 48]});
                chk($sformatf("round_%0d", hs), {60'd0, round}, 64'(hs));
                hs++;
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                held_sk  = subkey;
                held_rnd = round;
            end
            @(negedge clk);
            cyc++;
        end
        start        = 1'b0;
        key          = k;
        decrypt      = d;
        subkey_ready = 1'b0;
        chk("handshakes", 64'(hs), 64'd16);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("idle_after", {62'd0, subkey_valid, busy}, 64'd0);
        @(negedge clk);
        chk("done_once", {62'd0, done, subkey_valid}, 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen_done;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        key          = 64'd0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;

        ks[0]  = 48'h1B02EFFC7072; ks[1]  = 48'h79AED9DBC9E5;
        ks[2]  = 48'h55FC8A42CF99; ks[3]  = 48'h72ADD6DB351D;
        ks[4]  = 48'h7CEC07EB53A8; ks[5]  = 48'h63A53E507B2F;
        ks[6]  = 48'hEC84B7F618BC; ks[7]  = 48'hF78A3AC13BFB;
        ks[8]  = 48'hE0DBEBEDE781; ks[9]  = 48'hB1F347BA464F;
        ks[10] = 48'h215FD3DED386; ks[11] = 48'h7571F59467E9;
        ks[12] = 48'h97C5D1FABA41; ks[13] = 48'h5F43B7F2E73A;
        ks[14] = 48'hBF918D3D3F0A; ks[15] = 48'hCB3D8B0E17F5;

        main_key = 64'h133457799BBCDFF1;
        for (int i = 0; i < 16; i++) begin
            enc_exp[i*48 +: 48] = ks[i];
        end
        vecs[0].key = main_key;               vecs[0].dec = 1'b0; vecs[0].exp = enc_exp;
        vecs[1].key = main_key;               vecs[1].dec = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vecs[1].exp[i*48 +: 48] = ks[15-i];
        end
        vecs[2].key = 64'h0101010101010101;   vecs[2].dec = 1'b0; vecs[2].exp = '0;
        vecs[3].key = 64'hFEFEFEFEFEFEFEFE;   vecs[3].dec = 1'b1; vecs[3].exp = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_key_err", {63'd0, key_err}, 64'd0);
        chk("rst_round", {60'd0, round}, 64'd0);
        chk("rst_subkey", {16'd0, subkey}, 64'd0);

        // Table-driven schedules, ready held high
        for (int v = 0; v < 4; v++) begin
            run_sched(vecs[v].key, vecs[v].dec, vecs[v].exp, 1'b0, 1'b0);
        end

        // Random backpressure: same sequence, stable outputs during stalls
        run_sched(main_key, 1'b0, enc_exp, 1'b1, 1'b0);

        // Start/key/decrypt noise while busy is ignored; start right after done works
        run_sched(main_key, 1'b0, enc_exp, 1'b0, 1'b1);
        run_sched(main_key, 1'b0, enc_exp, 1'b0, 1'b0);

        // Reset in the middle of a schedule
        key          = main_key;
        decrypt      = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        subkey_ready = 1'b1;
        cyc          = 0;
        while (round != 4'd8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_round8", {60'd0, round}, 64'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid_busy", {62'd0, subkey_valid, busy}, 64'd0);
        chk("midrst_round", {60'd0, round}, 64'd0);
        chk("midrst_subkey", {16'd0, subkey}, 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", {63'd0, seen_done}, 64'd0);
        subkey_ready = 1'b0;

`ifdef DES_KEY_PARITY_CHECK_EN
        // Even-parity last byte: start rejected
        key   = 64'h133457799BBCDFF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("par_key_err", {63'd0, key_err}, 64'd1);
        chk("par_not_busy", {62'd0, busy, subkey_valid}, 64'd0);
        @(negedge clk);
        run_sched(main_key, 1'b0, enc_exp, 1'b0, 1'b0);
        chk("par_err_cleared", {63'd0, key_err}, 64'd0);
`else
        // Parity bit is dropped by PC-1: same subkeys, no error flag
        run_sched(64'h133457799BBCDFF0, 1'b0, enc_exp, 1'b0, 1'b0);
        chk("no_par_key_err", {63'd0, key_err}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
